data_memory_responder: RTL

// - Responder end of the processor data-memory bus: accepts load/store requests, stores data, returns load data.
// - Sits between the RISC-V 32I core's memory stage and on-chip data RAM.
// - Adds a request handshake, programmable wait states and RV32I SB/SH/SW/LB/LH/LW/LBU/LHU lane handling.

---
 rtl/data_memory_pkg.sv | 25 ++
 rtl/byte_lane_aligner.sv | 48 ++++
 rtl/data_memory_responder.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/data_memory_pkg.sv
// Shared types, size codes and alignment helper for the data-memory responder.
package data_memory_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  // Size code 2'b11 is treated as a word access.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    logic r_bad;
    r_bad = 1'b0;
    if (size == SIZE_HALF)
      r_bad = addr_lo[0];
    else if (size != SIZE_BYTE)
      r_bad = (addr_lo != 2'b00);
    return r_bad;
  endfunction

endpackage

// File: rtl/byte_lane_aligner.sv
// Combinational RV32I lane handling: store byte enables / lane replication,
// and load lane extraction with sign or zero extension.
module byte_lane_aligner
  import data_memory_pkg::*;
(
  input  logic [1:0]  i_size,
  input  logic [1:0]  i_addrLo,
  input  logic        i_unsigned,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rword,
  output logic [3:0]  o_byteEn,
  output logic [31:0] o_wdataLanes,
  output logic [31:0] o_rdata
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_byte = i_rword[{i_addrLo, 3'b000} +: 8];
  assign w_half = i_rword[{i_addrLo[1], 4'b0000} +: 16];

  // Replicating the low lanes lets the byte enables alone pick the target lanes.
  always_comb begin
    o_byteEn     = 4'b1111;
    o_wdataLanes = i_wdata;
    case (i_size)
      SIZE_BYTE: begin
        o_byteEn     = 4'b0001 << i_addrLo;
        o_wdataLanes = {4{i_wdata[7:0]}};
      end
      SIZE_HALF: begin
        o_byteEn     = i_addrLo[1] ? 4'b1100 : 4'b0011;
        o_wdataLanes = {2{i_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    o_rdata = i_rword;
    case (i_size)
      SIZE_BYTE: o_rdata = {{24{~i_unsigned & w_byte[7]}}, w_byte};
      SIZE_HALF: o_rdata = {{16{~i_unsigned & w_half[15]}}, w_half};
      default: ;
    endcase
  end

endmodule

// File: rtl/data_memory_responder.sv
// Data-memory responder: request handshake, programmable wait states, RAM.
// Optional alignment checking is enabled with `define DMEM_ALIGN_CHECK_EN.
module data_memory_responder
  import data_memory_pkg::*;
#(
  parameter int DEPTH_WORDS = 64,
  parameter int WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_error
);

  localparam int         IDX_W     = $clog2(DEPTH_WORDS);
  localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  state_t           r_state, w_nextState;
  logic [3:0]       r_waitCnt;
  logic             r_write, r_unsigned;
  logic [IDX_W+1:0] r_addr;
  logic [31:0]      r_wdata;
  logic [1:0]       r_size;
  logic [31:0]      r_rdata;
  logic [31:0]      r_mem [DEPTH_WORDS];

  logic             w_accept, w_enterResp, w_misalign, w_commit;
  logic             w_selWrite, w_selUnsigned;
  logic [IDX_W+1:0] w_selAddr;
  logic [31:0]      w_selWdata;
  logic [1:0]       w_selSize;
  logic [IDX_W-1:0] w_index;
  logic [3:0]       w_byteEn;
  logic [31:0]      w_wdataLanes, w_loadData;
  logic             w_unused;

  assign w_unused = &{1'b0, req_addr[31:IDX_W+2]};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    req_ready   = 1'b0;
    rsp_valid   = 1'b0;
    w_accept    = 1'b0;
    w_enterResp = 1'b0;
    case (r_state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          w_accept = 1'b1;
          if (WAIT_STATES > 0) begin
            w_nextState = WAIT;
          end else begin
            w_nextState = RESP;
            w_enterResp = 1'b1;
          end
        end
      end
      WAIT: begin
        if (r_waitCnt == 4'd0) begin
          w_nextState = RESP;
          w_enterResp = 1'b1;
        end
      end
      RESP: begin
        rsp_valid   = 1'b1;
        w_nextState = IDLE;
      end
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_waitCnt  <= 4'd0;
      r_write    <= 1'b0;
      r_unsigned <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= 32'd0;
      r_size     <= SIZE_BYTE;
    end else if (w_accept) begin
      r_waitCnt  <= WAIT_LOAD;
      r_write    <= req_write;
      r_unsigned <= req_unsigned;
      r_addr     <= req_addr[IDX_W+1:0];
      r_wdata    <= req_wdata;
      r_size     <= req_size;
    end else if (r_state == WAIT && r_waitCnt != 4'd0) begin
      r_waitCnt  <= r_waitCnt - 4'd1;
    end
  end

  // With zero wait states the response is launched straight from IDLE,
  // before the capture registers hold the request.
  assign w_selWrite    = (r_state == IDLE) ? req_write             : r_write;
  assign w_selUnsigned = (r_state == IDLE) ? req_unsigned          : r_unsigned;
  assign w_selAddr     = (r_state == IDLE) ? req_addr[IDX_W+1:0]   : r_addr;
  assign w_selWdata    = (r_state == IDLE) ? req_wdata             : r_wdata;
  assign w_selSize     = (r_state == IDLE) ? req_size              : r_size;
  assign w_index       = w_selAddr[IDX_W+1:2];

`ifdef DMEM_ALIGN_CHECK_EN
  logic r_error;
  assign w_misalign = is_misaligned(w_selSize, w_selAddr[1:0]);
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)           r_error <= 1'b0;
    else if (w_enterResp) r_error <= w_misalign;
  end
  assign rsp_error = r_error;
`else
  assign w_misalign = 1'b0;
  assign rsp_error  = 1'b0;
`endif

  byte_lane_aligner u_aligner (
    .i_size       (w_selSize),
    .i_addrLo     (w_selAddr[1:0]),
    .i_unsigned   (w_selUnsigned),
    .i_wdata      (w_selWdata),
    .i_rword      (r_mem[w_index]),
    .o_byteEn     (w_byteEn),
    .o_wdataLanes (w_wdataLanes),
    .o_rdata      (w_loadData)
  );

  assign w_commit = w_enterResp & w_selWrite & ~w_misalign & reset;

  always_ff @(posedge clk) begin
    if (w_commit) begin
      for (int i = 0; i < 4; i++)
        if (w_byteEn[i]) r_mem[w_index][8*i +: 8] <= w_wdataLanes[8*i +: 8];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)           r_rdata <= 32'd0;
    else if (w_enterResp) r_rdata <= (w_selWrite || w_misalign) ? 32'd0 : w_loadData;
  end

  assign rsp_rdata = r_rdata;

endmodule
